// File: rtl/seg_game_pkg.sv
// Shared constants for the seven-segment drawing game: FSM encodings, segment
// hit boxes on the OLED canvas and the digit-to-segment table.
package seg_game_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_LOSE  = 3'd4;

    localparam int unsigned NUM_SEGS  = 7;
    localparam logic [3:0]  SCORE_MAX = 4'd15;
    localparam logic [3:0]  DIGIT_BAD = 4'd15;

    typedef struct packed {
        logic [7:0] x_lo;
        logic [7:0] x_hi;
        logic [6:0] y_lo;
        logic [6:0] y_hi;
    } hit_box_t;

    // Inclusive bounds; boxes overlap at the corners of the digit outline.
    localparam hit_box_t SEG_BOX_0 = '{x_lo: 8'd9,  x_hi: 8'd29, y_lo: 7'd4,  y_hi: 7'd6};
    localparam hit_box_t SEG_BOX_1 = '{x_lo: 8'd27, x_hi: 8'd29, y_lo: 7'd4,  y_hi: 7'd27};
    localparam hit_box_t SEG_BOX_2 = '{x_lo: 8'd27, x_hi: 8'd29, y_lo: 7'd29, y_hi: 7'd47};
    localparam hit_box_t SEG_BOX_3 = '{x_lo: 8'd9,  x_hi: 8'd29, y_lo: 7'd45, y_hi: 7'd47};
    localparam hit_box_t SEG_BOX_4 = '{x_lo: 8'd9,  x_hi: 8'd11, y_lo: 7'd29, y_hi: 7'd47};
    localparam hit_box_t SEG_BOX_5 = '{x_lo: 8'd9,  x_hi: 8'd11, y_lo: 7'd4,  y_hi: 7'd27};
    localparam hit_box_t SEG_BOX_6 = '{x_lo: 8'd9,  x_hi: 8'd29, y_lo: 7'd26, y_hi: 7'd28};

    function automatic hit_box_t seg_box(input int idx);
        case (idx)
            0:       return SEG_BOX_0;
            1:       return SEG_BOX_1;
            2:       return SEG_BOX_2;
            3:       return SEG_BOX_3;
            4:       return SEG_BOX_4;
            5:       return SEG_BOX_5;
            default: return SEG_BOX_6;
        endcase
    endfunction

    function automatic logic cursor_in_box(input hit_box_t b, input logic [7:0] x,
                                           input logic [6:0] y);
        return (x >= b.x_lo) && (x <= b.x_hi) && (y >= b.y_lo) && (y <= b.y_hi);
    endfunction

    // Bit 0 = segment a ... bit 6 = segment g.
    function automatic logic [6:0] digit_mask(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // (t + 7) mod 10 for t in 0..9.
    function automatic logic [3:0] next_target(input logic [3:0] t);
        return (t >= 4'd3) ? t - 4'd3 : t + 4'd7;
    endfunction

endpackage

// File: rtl/seg_hit_test.sv
// Combinational cursor hit test: returns the single lowest-index segment whose
// box contains the cursor, plus a flag that any box was hit.
module seg_hit_test
    import seg_game_pkg::*;
(
    input  logic [7:0] x_cursor,
    input  logic [6:0] y_cursor,
    output logic [6:0] hit,
    output logic       hit_valid
);

    logic [NUM_SEGS-1:0] in_box;

    always_comb begin
        for (int i = 0; i < NUM_SEGS; i++) begin
            in_box[i] = cursor_in_box(seg_box(i), x_cursor, y_cursor);
        end
    end

    // Walk from the top so the lowest matching index is written last.
    always_comb begin
        hit = '0;
        for (int i = NUM_SEGS - 1; i >= 0; i--) begin
            if (in_box[i]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    assign hit_valid = |in_box;

endmodule

// File: rtl/segment_game_ctrl.sv
// Round controller for the draw-a-digit game: the player toggles segments with
// mouse clicks against a per-round timer, then the decoded digit is judged.
module segment_game_ctrl
    import seg_game_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned ROUND_SEC     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_submit,
    input  logic        mouse_left,
    input  logic [7:0]  x_cursor,
    input  logic [6:0]  y_cursor,
    input  logic [3:0]  correct_number,
    output logic [6:0]  mouse_click,
    output logic [3:0]  target,
    output logic [3:0]  time_left,
    output logic [3:0]  score,
    output logic [15:0] led,
    output logic [2:0]  state
);

    localparam int unsigned TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]  ROUND_TIME = 4'(ROUND_SEC);

    logic [2:0]        state_q, state_d;
    logic [6:0]        mask_q, mask_d;
    logic [3:0]        target_q, target_d;
    logic [3:0]        time_q, time_d;
    logic [3:0]        score_q, score_d;
    logic [15:0]       led_q, led_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    logic [6:0] hit;
    logic       hit_valid;
    logic       tick_wrap;
    logic       expire;

    seg_hit_test u_hit (
        .x_cursor  (x_cursor),
        .y_cursor  (y_cursor),
        .hit       (hit),
        .hit_valid (hit_valid)
    );

    assign tick_wrap = (tick_q == TICK_MAX);
    // Expiry is the wrap that takes the last second to zero.
    assign expire    = (time_q == 4'd0) || (tick_wrap && (time_q == 4'd1));

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        target_d = target_q;
        time_d   = time_q;
        score_d  = score_q;
        tick_d   = tick_q;

        case (state_q)
            ST_IDLE: begin
                if (btn_start) begin
                    state_d = ST_PLAY;
                    mask_d  = '0;
                    time_d  = ROUND_TIME;
                    tick_d  = '0;
                end
            end
            ST_PLAY: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                if (tick_wrap && (time_q != 4'd0)) begin
                    time_d = time_q - 4'd1;
                end
                if (btn_submit || expire) begin
                    state_d = ST_CHECK;
                end else if (mouse_left && hit_valid) begin
                    mask_d = mask_q ^ hit;
                end
            end
            ST_CHECK: begin
                if (correct_number == target_q) begin
                    state_d = ST_WIN;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOSE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (btn_start) begin
                    state_d  = ST_PLAY;
                    target_d = next_target(target_q);
                    mask_d   = '0;
                    time_d   = ROUND_TIME;
                    tick_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // LED bar is built from next-state values so it lines up with time_left.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < 10; i++) begin
            led_d[i] = (time_d > 4'(i));
        end
        led_d[15] = (state_d == ST_WIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            target_q <= 4'd1;
            time_q   <= ROUND_TIME;
            score_q  <= '0;
            led_q    <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            target_q <= target_d;
            time_q   <= time_d;
            score_q  <= score_d;
            led_q    <= led_d;
            tick_q   <= tick_d;
        end
    end

    assign mouse_click = mask_q;
    assign target      = target_q;
    assign time_left   = time_q;
    assign score       = score_q;
    assign led         = led_q;
    assign state       = state_q;

endmodule

// File: tb/tb_segment_game_ctrl.sv
// Directed bench for segment_game_ctrl with a queue-based scoreboard; the
// driver queues expected outputs per cycle and a monitor compares them.
module tb_segment_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_submit = 1'b0;
    logic        mouse_left = 1'b0;
    logic [7:0]  x_cursor = '0;
    logic [6:0]  y_cursor = '0;
    logic [3:0]  correct_number = 4'd15;
    logic [6:0]  mouse_click;
    logic [3:0]  target;
    logic [3:0]  time_left;
    logic [3:0]  score;
    logic [15:0] led;
    logic [2:0]  state;

    segment_game_ctrl #(
        .TICKS_PER_SEC (4),
        .ROUND_SEC     (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start      (btn_start),
        .btn_submit     (btn_submit),
        .mouse_left     (mouse_left),
        .x_cursor       (x_cursor),
        .y_cursor       (y_cursor),
        .correct_number (correct_number),
        .mouse_click    (mouse_click),
        .target         (target),
        .time_left      (time_left),
        .score          (score),
        .led            (led),
        .state          (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [37:0] val;
        logic [37:0] care;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tgt;

    // Queue an expectation for the outputs after the most recent clock edge; -1 = don't care.
    task automatic expect_o(input string nm, input int st = -1, input int mc = -1,
                            input int tg = -1, input int tl = -1, input int sc = -1,
                            input int ld = -1);
        exp_t e;
        e.name = nm;
        e.val  = '0;
        e.care = '0;
        if (st >= 0) begin e.val[37:35] = st[2:0];  e.care[37:35] = '1; end
        if (ld >= 0) begin e.val[34:19] = ld[15:0]; e.care[34:19] = '1; end
        if (sc >= 0) begin e.val[18:15] = sc[3:0];  e.care[18:15] = '1; end
        if (tl >= 0) begin e.val[14:11] = tl[3:0];  e.care[14:11] = '1; end
        if (tg >= 0) begin e.val[10:7]  = tg[3:0];  e.care[10:7]  = '1; end
        if (mc >= 0) begin e.val[6:0]   = mc[6:0];  e.care[6:0]   = '1; end
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle presents a settled result.
    always @(negedge clk) begin
        exp_t        e;
        logic [37:0] act;
        #1;
        act = {state, led, score, time_left, target, mouse_click};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ((act & e.care) !== (e.val & e.care)) begin
                errors++;
                $display("FAIL %s: got %h required %h (care %h)", e.name, act & e.care,
                         e.val & e.care, e.care);
            end
        end
    end

    // One clock with the given pulses; returns at the next negedge with pulses dropped.
    task automatic step(input logic s = 1'b0, input logic sub = 1'b0, input logic ml = 1'b0,
                        input int x = 0, input int y = 0);
        btn_start  = s;
        btn_submit = sub;
        mouse_left = ml;
        x_cursor   = x[7:0];
        y_cursor   = y[6:0];
        @(negedge clk);
        btn_start  = 1'b0;
        btn_submit = 1'b0;
        mouse_left = 1'b0;
    endtask

    function automatic int nxt(input int t);
        return (t + 7) % 10;
    endfunction

    function automatic int therm(input int t);
        int n;
        n = (t > 10) ? 10 : t;
        return (1 << n) - 1;
    endfunction

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step();
        expect_o("reset", 0, 0, 1, 3, 0, 0);
        rst = 1'b0;
        tgt = 1;

        // Draw a "1" and win.
        step(1'b1);
        expect_o("start_play", 1, 0, tgt, 3, 0);
        step(1'b0, 1'b0, 1'b1, 28, 10);
        expect_o("click_seg1", 1, 7'b0000010);
        step(1'b0, 1'b0, 1'b1, 28, 30);
        expect_o("click_seg2", 1, 7'b0000110);
        correct_number = 4'd1;
        step(1'b0, 1'b1);
        expect_o("submit_check", 2, 7'b0000110);
        step();
        expect_o("win", 3, 7'b0000110, 1, 3, 1, 16'h8007);

        // Next target, then a wrong digit loses.
        tgt = nxt(tgt);
        correct_number = 4'd15;
        step(1'b1);
        expect_o("restart_from_win", 1, 0, tgt, 3, 1, 16'h0007);
        step(1'b0, 1'b1);
        expect_o("submit_bad", 2);
        step();
        expect_o("lose", 4, 0, 8, 3, 1, 16'h0007);
        step(1'b0, 1'b1);
        expect_o("submit_ignored_lose", 4, 0, 8, 3, 1);

        // Idle round runs out of time.
        tgt = nxt(tgt);
        step(1'b1);
        expect_o("timer_start", 1, 0, tgt, 3, 1, 16'h0007);
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3) expect_o("timer_hold_3", 1, -1, -1, 3, -1, 16'h0007);
            if (i % 4 == 0) expect_o("timer_step", (i == 12) ? 2 : 1, -1, -1, 3 - i / 4,
                                     -1, therm(3 - i / 4));
        end
        step();
        expect_o("timeout_lose", 4, 0, tgt, 0, 1, 0);

        // Toggle and overlap behaviour.
        tgt = nxt(tgt);
        step(1'b1);
        expect_o("toggle_start", 1, 0, tgt, 3);
        step(1'b0, 1'b0, 1'b1, 28, 10);
        expect_o("toggle_on", 1, 7'b0000010);
        step(1'b0, 1'b0, 1'b1, 28, 10);
        expect_o("toggle_off", 1, 7'b0000000);
        step(1'b0, 1'b0, 1'b1, 10, 5);
        expect_o("overlap_seg0_seg5", 1, 7'b0000001);
        // (28,5) also lies in seg0's box, which wins over seg1.
        step(1'b0, 1'b0, 1'b1, 28, 5);
        expect_o("overlap_seg0_seg1", 1, 7'b0000000);
        step(1'b0, 1'b0, 1'b1, 50, 50);
        expect_o("outside_all", 1, 7'b0000000);
        step(1'b0, 1'b0, 1'b1, 10, 27);
        expect_o("overlap_seg5_seg6", 1, 7'b0100000);
        step(1'b0, 1'b1, 1'b1, 28, 30);
        expect_o("submit_with_click", 2, 7'b0100000);
        step();
        expect_o("submit_click_lose", 4, 7'b0100000, tgt, -1, 1);

        // Expiry coincident with a click.
        tgt = nxt(tgt);
        step(1'b1);
        expect_o("exp_click_start", 1, 0, tgt, 3);
        for (int i = 1; i <= 11; i++) step();
        expect_o("exp_click_pre", 1, 0, -1, 1);
        step(1'b0, 1'b0, 1'b1, 28, 30);
        expect_o("expire_with_click", 2, 0, -1, 0);
        step();
        expect_o("expire_click_lose", 4, 0);

        // Submit, expiry and click all together -> exactly one CHECK.
        tgt = nxt(tgt);
        step(1'b1);
        expect_o("triple_start", 1, 0, tgt, 3);
        for (int i = 1; i <= 11; i++) step();
        step(1'b0, 1'b1, 1'b1, 28, 30);
        expect_o("triple_check", 2, 0, -1, 0);
        step();
        expect_o("triple_lose", 4, 0, tgt, 0, 1);
        step();
        expect_o("triple_single_check", 4, 0, tgt, 0, 1);

        // Win four rounds to reach score 5.
        for (int k = 0; k < 4; k++) begin
            tgt = nxt(tgt);
            correct_number = tgt[3:0];
            step(1'b1);
            step(1'b0, 1'b1);
            step();
            expect_o("win_to_five", 3, -1, tgt, -1, 2 + k);
        end

        // Full mask, then reset mid-round with competing inputs.
        tgt = nxt(tgt);
        correct_number = 4'd15;
        step(1'b1);
        step(1'b0, 1'b0, 1'b1, 20, 5);
        step(1'b0, 1'b0, 1'b1, 28, 10);
        step(1'b0, 1'b0, 1'b1, 28, 30);
        step(1'b0, 1'b0, 1'b1, 20, 46);
        step(1'b0, 1'b0, 1'b1, 10, 35);
        step(1'b0, 1'b0, 1'b1, 10, 10);
        step(1'b0, 1'b0, 1'b1, 20, 27);
        expect_o("full_mask", 1, 7'b1111111, tgt, -1, 5);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 28, 10);
        expect_o("reset_mid_play", 0, 0, 1, 3, 0, 0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 28, 10);
        expect_o("idle_ignores_inputs", 0, 0, 1, 3, 0);

        // Sixteen wins saturate the score at 15.
        tgt = 1;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tgt = nxt(tgt);
            correct_number = tgt[3:0];
            step(1'b1);
            step(1'b0, 1'b1);
            step();
            if (k >= 13) expect_o("score_saturate", 3, -1, tgt, -1, (k + 1 > 15) ? 15 : k + 1);
        end
        step();
        expect_o("score_hold", 3, -1, -1, -1, 15);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
